// File: rtl/dro_pkg.sv
// Shared definitions for the DRO bank: the count-width helper and the
// output-mode constants selected by the OUT_TOGGLE parameter.
package dro_pkg;

    // Output mode: a readout either pulses out for one clock or toggles it
    localparam int OUT_PULSE  = 0;
    localparam int OUT_TOGGLE = 1;

    // Width needed to hold 0..n; never narrower than one bit
    function automatic int cnt_width(input int n);
        if (n < 1) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dro_cell.sv
// One DRO channel: fluxon count, readout output, sticky overflow/violation
// flags and, when DRO_BANK_VIOLATION_EN is defined, set/read spacing timers.
module dro_cell #(
    parameter int DEPTH      = 1,
    parameter int CT_CYCLES  = 2,
    parameter int OUT_TOGGLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_set,
    input  logic i_read,
    input  logic i_clr,
    output logic o_out,
    output logic o_state,
    output logic o_overflow,
    output logic o_viol
);
    import dro_pkg::*;

    localparam int CW = cnt_width(DEPTH);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_out;
    logic          r_overflow;
    logic          r_viol;
    logic          w_empty;
    logic          w_full;
    logic          w_rd_ev;
    logic          w_ovf_ev;
    logic          w_viol_ev;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    // Any read against a non-empty store produces a readout, even with a set
    assign w_rd_ev  = i_read & ~w_empty;
    assign w_ovf_ev = i_set & ~i_read & w_full;

    // Next fluxon count; a simultaneous set+read either swaps (count kept)
    // or, when empty, simply stores the new fluxon
    always_comb begin
        w_count_next = r_count;
        if (i_set && !i_read && !w_full) begin
            w_count_next = r_count + CW'(1);
        end else if (!i_set && i_read && !w_empty) begin
            w_count_next = r_count - CW'(1);
        end else if (i_set && i_read && w_empty) begin
            w_count_next = CW'(1);
        end
    end

`ifdef DRO_BANK_VIOLATION_EN
    localparam int TW = cnt_width(CT_CYCLES);

    // Clocks elapsed since the last set/read, saturating at CT_CYCLES
    logic [TW-1:0] r_since_set;
    logic [TW-1:0] r_since_read;

    // Distance to the previous opposite event is timer+1; same cycle is 0
    assign w_viol_ev = (i_set & i_read & (CT_CYCLES > 0))
                     | (i_read & ((int'(r_since_set) + 1) < CT_CYCLES))
                     | (i_set & ((int'(r_since_read) + 1) < CT_CYCLES));

    // Spacing timers restart on their own event and otherwise count up
    always_ff @(posedge clk) begin
        if (rst) begin
            r_since_set  <= TW'(CT_CYCLES);
            r_since_read <= TW'(CT_CYCLES);
        end else begin
            if (i_set) begin
                r_since_set <= '0;
            end else if (r_since_set != TW'(CT_CYCLES)) begin
                r_since_set <= r_since_set + TW'(1);
            end
            if (i_read) begin
                r_since_read <= '0;
            end else if (r_since_read != TW'(CT_CYCLES)) begin
                r_since_read <= r_since_read + TW'(1);
            end
        end
    end
`else
    assign w_viol_ev = 1'b0;
`endif

    // Count, readout output and sticky flags; a new flag event beats clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_out      <= 1'b0;
            r_overflow <= 1'b0;
            r_viol     <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (OUT_TOGGLE == OUT_PULSE) begin
                r_out <= w_rd_ev;
            end else begin
                r_out <= r_out ^ w_rd_ev;
            end
            r_overflow <= (r_overflow & ~i_clr) | w_ovf_ev;
            r_viol     <= (r_viol & ~i_clr) | w_viol_ev;
        end
    end

    assign o_out      = r_out;
    assign o_state    = ~w_empty;
    assign o_overflow = r_overflow;
    assign o_viol     = r_viol;

endmodule

// File: rtl/dro_bank.sv
// Bank of CH independent destructive-readout (DRO) storage channels.
// Optional spacing-violation detection is compiled in with the macro
// DRO_BANK_VIOLATION_EN; without it viol reads constant 0.
module dro_bank #(
    parameter int CH         = 4,
    parameter int DEPTH      = 1,
    parameter int CT_CYCLES  = 2,
    parameter int OUT_TOGGLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] set,
    input  logic [CH-1:0] read,
    input  logic          clr_flags,
    output logic [CH-1:0] out,
    output logic [CH-1:0] state,
    output logic [CH-1:0] overflow,
    output logic [CH-1:0] viol
);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_cell
            dro_cell #(
                .DEPTH      (DEPTH),
                .CT_CYCLES  (CT_CYCLES),
                .OUT_TOGGLE (OUT_TOGGLE)
            ) u_cell (
                .clk        (clk),
                .rst        (rst),
                .i_set      (set[gi]),
                .i_read     (read[gi]),
                .i_clr      (clr_flags),
                .o_out      (out[gi]),
                .o_state    (state[gi]),
                .o_overflow (overflow[gi]),
                .o_viol     (viol[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_dro_bank.sv
// Directed self-checking bench for dro_bank: a classic DRO bank (DEPTH=1,
// toggle output) and a DEPTH=3 pulse-output bank share clock and reset.
module tb_dro_bank;

`ifdef DRO_BANK_VIOLATION_EN
    localparam bit VEN = 1'b1;
`else
    localparam bit VEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_flags;
    logic [3:0] set_a, read_a, out_a, state_a, ovf_a, viol_a;
    logic [3:0] set_b, read_b, out_b, state_b, ovf_b, viol_b;
    logic       clr_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dro_bank #(.CH(4), .DEPTH(1), .CT_CYCLES(2), .OUT_TOGGLE(1)) dut_a (
        .clk(clk), .rst(rst), .set(set_a), .read(read_a), .clr_flags(clr_flags),
        .out(out_a), .state(state_a), .overflow(ovf_a), .viol(viol_a)
    );

    dro_bank #(.CH(4), .DEPTH(3), .CT_CYCLES(2), .OUT_TOGGLE(0)) dut_b (
        .clk(clk), .rst(rst), .set(set_b), .read(read_b), .clr_flags(clr_b),
        .out(out_b), .state(state_b), .overflow(ovf_b), .viol(viol_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("chk  %s = %0h", tag, got);
        end
    endtask

    // Let one active edge capture the current inputs, then settle
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; clr_flags = 1'b0; clr_b = 1'b0;
        set_a = 4'hF; read_a = 4'hF; set_b = 4'hF; read_b = 4'hF;
        tick(2);
        rst = 1'b0; set_a = '0; read_a = '0; set_b = '0; read_b = '0;
        tick();
        chk("rst_state", state_a, 4'h0);
        chk("rst_out", out_a, 4'h0);
        chk("rst_ovf", ovf_a, 4'h0);
        chk("rst_viol", viol_a, 4'h0);
        chk("rst_state_b", state_b, 4'h0);

        // Classic store then destructive read on ch0
        set_a = 4'b0001; tick(); set_a = '0;
        chk("ch0_stored", state_a, 4'b0001);
        chk("ch0_out_idle", out_a, 4'b0000);
        tick(3);
        chk("ch0_held", state_a, 4'b0001);
        read_a = 4'b0001; tick(); read_a = '0;
        chk("ch0_read_out", out_a, 4'b0001);
        chk("ch0_read_state", state_a, 4'b0000);
        read_a = 4'b0001; tick(); read_a = '0;
        chk("ch0_empty_read_out", out_a, 4'b0001);
        chk("ch0_viol", viol_a, 4'b0000);

        // Simultaneous set+read on ch2 at count 1 and count 0
        set_a = 4'b0100; tick(); set_a = '0;
        chk("ch2_stored", state_a, 4'b0100);
        tick(3);
        set_a = 4'b0100; read_a = 4'b0100; tick(); set_a = '0; read_a = '0;
        chk("ch2_swap_out", out_a, 4'b0101);
        chk("ch2_swap_state", state_a, 4'b0100);
        chk("ch2_swap_viol", viol_a, VEN ? 4'b0100 : 4'b0000);
        tick(3);
        read_a = 4'b0100; tick(); read_a = '0;
        chk("ch2_drain_out", out_a, 4'b0001);
        chk("ch2_drain_state", state_a, 4'b0000);
        tick(3);
        set_a = 4'b0100; read_a = 4'b0100; tick(); set_a = '0; read_a = '0;
        chk("ch2_empty_swap_out", out_a, 4'b0001);
        chk("ch2_empty_swap_state", state_a, 4'b0100);

        // Overflow on ch1, clear racing a new overflow event
        set_a = 4'b0010; tick(); set_a = '0; tick();
        set_a = 4'b0010; tick(); set_a = '0;
        chk("ch1_ovf", ovf_a, 4'b0010);
        chk("ch1_ovf_state", state_a, 4'b0110);
        clr_flags = 1'b1; set_a = 4'b0010; tick(); set_a = '0;
        chk("ch1_clr_race", ovf_a, 4'b0010);
        tick(); clr_flags = 1'b0;
        chk("ch1_clr_ovf", ovf_a, 4'b0000);
        chk("clr_viol", viol_a, 4'b0000);

        // Spacing violation on ch3: read one clock after set
        set_a = 4'b1000; tick(); set_a = '0;
        read_a = 4'b1000; tick(); read_a = '0;
        chk("ch3_out", out_a, 4'b1001);
        chk("ch3_viol", viol_a, VEN ? 4'b1000 : 4'b0000);
        chk("ch3_state", state_a, 4'b0110);
        tick();
        chk("ch3_viol_sticky", viol_a, VEN ? 4'b1000 : 4'b0000);
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        chk("ch3_viol_clr", viol_a, 4'b0000);

        // Fill every channel, then reset with reads asserted
        tick(2);
        set_a = 4'hF; tick(); set_a = '0;
        chk("fill_state", state_a, 4'hF);
        chk("fill_ovf", ovf_a, 4'b0110);
        chk("fill_viol", viol_a, 4'b0000);
        rst = 1'b1; read_a = 4'hF; tick(); rst = 1'b0; read_a = '0;
        chk("mid_rst_state", state_a, 4'h0);
        chk("mid_rst_out", out_a, 4'h0);
        chk("mid_rst_ovf", ovf_a, 4'h0);
        tick();
        read_a = 4'hF; tick(); read_a = '0;
        chk("post_rst_read_out", out_a, 4'h0);
        chk("post_rst_viol", viol_a, 4'h0);

        // DEPTH=3 pulse bank: 4 sets then 4 reads on ch1
        for (int k = 0; k < 4; k++) begin
            set_b = 4'b0010; tick();
            if (k == 0) chk("b_set1_state", state_b, 4'b0010);
            if (k == 2) chk("b_set3_ovf", ovf_b, 4'b0000);
            if (k == 3) chk("b_set4_ovf", ovf_b, 4'b0010);
        end
        set_b = '0;
        tick(3);
        for (int k = 0; k < 4; k++) begin
            read_b = 4'b0010; tick();
            chk($sformatf("b_read%0d_out", k + 1), out_b, (k < 3) ? 4'b0010 : 4'b0000);
            if (k == 2) chk("b_read3_state", state_b, 4'b0000);
        end
        read_b = '0; tick();
        chk("b_idle_out", out_b, 4'b0000);
        chk("b_viol", viol_b, 4'b0000);
        chk("b_ovf_sticky", ovf_b, 4'b0010);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dro_bank.md
DRO_BANK -- requirements
Module: dro_bank

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent DRO channels.
REQ-002 SHALL have parameter DEPTH, default 1: fluxons storable per channel (1 = classic DRO).
REQ-003 SHALL have parameter CT_CYCLES, default 2: minimum set/read spacing in clocks.
REQ-004 SHALL have parameter OUT_TOGGLE, default 1: 1 = out toggles per read; 0 = out pulses one cycle.
REQ-005 SHALL have port clk  input  1  sole clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port set  input  CH  per-channel store request, sampled each rising clk.
REQ-008 SHALL have port read  input  CH  per-channel destructive readout request.
REQ-009 SHALL have port clr_flags  input  1  clears all sticky flags.
REQ-010 SHALL have port out  output  CH  readout output, registered.
REQ-011 SHALL have port state  output  CH  per-channel: stored count != 0.
REQ-012 SHALL have port overflow  output  CH  sticky: set dropped at full.
REQ-013 SHALL have port viol  output  CH  sticky: spacing violation (see Configuration).

Function
REQ-014 SHALL keep per-channel count, 0..DEPTH, width $clog2(DEPTH+1).
REQ-015 set only, count<DEPTH: count+1 next cycle.
REQ-016 set only, count==DEPTH: count unchanged, overflow[i] set next cycle.
REQ-017 read only, count>0: count-1, one readout event next cycle.
REQ-018 read only, count==0: no readout, no state change.
REQ-019 set and read same cycle, count>0: count unchanged, one readout event.
REQ-020 set and read same cycle, count==0: count becomes 1, no readout.
REQ-021 readout event, OUT_TOGGLE=1: out[i] inverts; OUT_TOGGLE=0: out[i] high exactly one cycle.
REQ-022 out SHALL reflect a read sampled at edge N on edge N+1: one-cycle latency.
REQ-023 state[i] SHALL be combinational from registered count (no extra latency).
REQ-024 clr_flags SHALL clear overflow and viol; a new flag event in the same cycle wins (flag stays 1).
REQ-025 channels SHALL be fully independent; no cross-channel interaction.

Reset
REQ-026 rst high SHALL force count=0, out=0, overflow=0, viol=0, spacing timers saturated at CT_CYCLES.
REQ-027 set/read asserted while rst high SHALL be ignored entirely.
REQ-028 rst mid-operation SHALL discard stored fluxons with no readout emitted.

Configuration
REQ-029 Macro DRO_BANK_VIOLATION_EN SHALL compile in per-channel spacing timers and viol logic.
REQ-030 With macro: viol[i] sets when read arrives <CT_CYCLES clocks after set, or set <CT_CYCLES after read, same channel; simultaneous = distance 0 = violation.
REQ-031 With macro: violation SHALL NOT alter count/out behaviour; flag only.
REQ-032 Without macro: viol tied 0, no timer registers synthesised; port retained.

Structure
REQ-033 Package dro_pkg SHALL hold the count-width function and the out-mode constants (OUT_PULSE=0, OUT_TOGGLE=1).
REQ-034 One sub-module dro_cell (single channel: count, out, flags, timers) SHALL be instantiated CH times via generate.

Verification
REQ-035 DEPTH=1, CH=4: set[0] at cycle 5, read[0] at cycle 10 -> out[0] 0->1 at cycle 11, state[0] 1 during cycles 6-10, 0 from 11.
REQ-036 DEPTH=3, OUT_TOGGLE=0: 4 sets on ch1 cycles 5-8, then 4 reads cycles 12-15 -> overflow[1]=1 at cycle 9, exactly 3 one-cycle out[1] pulses at cycles 13-15, none for the 4th read.
REQ-037 count=1 on ch2, set and read in same cycle -> one readout, count stays 1; repeat at count=0 -> no readout, count 1.
REQ-038 macro on, CT_CYCLES=2: set[3] cycle 5, read[3] cycle 6 -> viol[3]=1 at cycle 7, readout still emitted; clr_flags cycle 9 -> viol[3]=0 at cycle 10.
REQ-039 count=1 on all channels, rst high cycle 20 with read=4'hF -> count 0, out 0, no readout; read at cycle 22 -> no readout.
REQ-040 macro off: same stimulus as REQ-038 -> viol stays 0, readout identical.
